// File: rtl/proc_pkg.sv
// Shared processor definitions: opcode constants, instruction field
// positions, fetch FSM state encoding and the latched fetch payload type.
package proc_pkg;

  localparam int unsigned WORD_W = 16;

  // Instruction field layout: op [3:0], rX [6:4], rY [9:7]
  localparam int unsigned OP_LSB = 0;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned RX_LSB = 4;
  localparam int unsigned RY_LSB = 7;
  localparam int unsigned REG_W  = 3;

  // Opcodes
  localparam logic [OP_W-1:0] OP_MVNZ = 4'b0010;
  localparam logic [OP_W-1:0] OP_MV   = 4'b0011;
  localparam logic [OP_W-1:0] OP_MVI  = 4'b0100;

  // Fetch FSM states
  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_e;

  // Instruction word plus its immediate, as captured from the TLB
  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] imm;
    logic              imm_valid;
  } fetch_word_t;

  // True when the word's opcode field is MVI (carries an immediate)
  function automatic logic is_mvi(input logic [WORD_W-1:0] word);
    return word[OP_LSB +: OP_W] == OP_MVI;
  endfunction

endpackage

// File: rtl/pc_counter.sv
// Program counter register with load (priority) and increment.
// Ports:
//   clk, rst_n  - clock, async active-low reset (pc <= RESET_PC)
//   load        - load pc from load_value
//   load_value  - redirect target
//   inc         - advance pc by one (wraps 16'hFFFF -> 16'h0000)
//   pc          - current program counter
module pc_counter
  import proc_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = 16'd1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WORD_W-1:0] load_value,
  input  logic              inc,
  output logic [WORD_W-1:0] pc
);

  // Load wins over increment so a redirect coincident with a handshake sticks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_value;
    end else if (inc) begin
      pc <= pc + WORD_W'(1);
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: issues pc to the TLB, retries on misses up to
// MAX_RETRY times before raising a sticky fault, and holds the fetched
// instruction/immediate until the consumer accepts it.
// Ports:
//   Clock, Resetn        - clock, async active-low reset
//   tlb_addr             - virtual address to TLB (always equals pc)
//   tlb_din, tlb_data    - instruction and immediate words from TLB
//   tlb_hit              - TLB hit for tlb_addr
//   pc_load, pc_load_value - redirect request and target
//   instr_valid, instr_ready - output handshake
//   instr, imm, imm_valid  - latched instruction, immediate, MVI flag
//   fault                - sticky fetch fault
//   pc                   - current fetch pc
module instruction_fetch
  import proc_pkg::*;
#(
  parameter int unsigned       MAX_RETRY = 3,
  parameter logic [WORD_W-1:0] RESET_PC  = 16'd1
) (
  input  logic              Clock,
  input  logic              Resetn,
  output logic [WORD_W-1:0] tlb_addr,
  input  logic [WORD_W-1:0] tlb_din,
  input  logic [WORD_W-1:0] tlb_data,
  input  logic              tlb_hit,
  input  logic              pc_load,
  input  logic [WORD_W-1:0] pc_load_value,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [WORD_W-1:0] instr,
  output logic [WORD_W-1:0] imm,
  output logic              imm_valid,
  output logic              fault,
  output logic [WORD_W-1:0] pc
);

  localparam int unsigned RETRY_W = (MAX_RETRY > 2) ? $clog2(MAX_RETRY) : 1;
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY - 1);

  fetch_state_e       state, state_next;
  logic [RETRY_W-1:0] retry_cnt, retry_next;
  logic               capture;
  logic               pc_inc;
  fetch_word_t        fetched;

  // State and retry counter registers
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state     <= ST_ISSUE;
      retry_cnt <= '0;
    end else begin
      state     <= state_next;
      retry_cnt <= retry_next;
    end
  end

  // Next-state, retry and datapath control
  always_comb begin
    state_next = state;
    retry_next = retry_cnt;
    capture    = 1'b0;
    pc_inc     = 1'b0;
    case (state)
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT: begin
        if (tlb_hit) begin
          capture    = 1'b1;
          retry_next = '0;
          state_next = ST_HOLD;
        end else if (retry_cnt == RETRY_LAST) begin
          retry_next = '0;
          state_next = ST_FAULT;
        end else begin
          retry_next = retry_cnt + RETRY_W'(1);
          state_next = ST_ISSUE;
        end
      end
      ST_HOLD: begin
        if (instr_ready) begin
          pc_inc     = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_FAULT: state_next = ST_FAULT;
      default:  state_next = ST_ISSUE;
    endcase
    // A redirect overrides everything, including a HOLD handshake
    if (pc_load) begin
      state_next = ST_ISSUE;
      retry_next = '0;
      capture    = 1'b0;
    end
  end

  // Fetched word latch; only written on a WAIT hit so it is stable in HOLD
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      fetched <= '0;
    end else if (capture) begin
      fetched <= '{instr: tlb_din, imm: tlb_data, imm_valid: is_mvi(tlb_din)};
    end
  end

  pc_counter #(
    .RESET_PC (RESET_PC)
  ) u_pc_counter (
    .clk        (Clock),
    .rst_n      (Resetn),
    .load       (pc_load),
    .load_value (pc_load_value),
    .inc        (pc_inc),
    .pc         (pc)
  );

  assign tlb_addr    = pc;
  assign instr_valid = (state == ST_HOLD);
  assign fault       = (state == ST_FAULT);
  assign instr       = fetched.instr;
  assign imm         = fetched.imm;
  assign imm_valid   = fetched.imm_valid;

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter MAX_RETRY, default 3: consecutive TLB misses tolerated before fault.
REQ-002 SHALL have parameter RESET_PC, default 16'd1: first fetch address after reset.
REQ-003 SHALL have port Clock  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port Resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port tlb_addr  output  16  virtual address driven to TLB enderecoVirtual.
REQ-006 SHALL have port tlb_din  input  16  instruction word returned by TLB (DIN).
REQ-007 SHALL have port tlb_data  input  16  immediate word returned by TLB (Data).
REQ-008 SHALL have port tlb_hit  input  1  TLB hit for current tlb_addr.
REQ-009 SHALL have port pc_load  input  1  redirect request (MVNZ/MV to R7).
REQ-010 SHALL have port pc_load_value  input  16  redirect target.
REQ-011 SHALL have port instr_valid  output  1  instr/imm hold a fetched instruction.
REQ-012 SHALL have port instr_ready  input  1  consumer accepts instruction.
REQ-013 SHALL have port instr  output  16  latched instruction word.
REQ-014 SHALL have port imm  output  16  latched immediate word.
REQ-015 SHALL have port imm_valid  output  1  latched instruction is MVI (instr[3:0]==4'b0100).
REQ-016 SHALL have port fault  output  1  sticky fetch fault.
REQ-017 SHALL have port pc  output  16  current fetch PC.

Function
REQ-018 SHALL implement FSM states ISSUE, WAIT, HOLD, FAULT.
REQ-019 ISSUE: tlb_addr=pc; next state WAIT unconditionally.
REQ-020 WAIT: tlb_addr=pc; tlb_hit=1 -> latch tlb_din to instr, tlb_data to imm, compute imm_valid, clear retry count, go HOLD.
REQ-021 WAIT with tlb_hit=0 -> retry count+1, go ISSUE; miss when count==MAX_RETRY-1 -> go FAULT, fault=1.
REQ-022 HOLD: instr_valid=1; instr/imm/imm_valid SHALL stay stable until instr_valid&&instr_ready.
REQ-023 HOLD with instr_ready=1 -> pc<=pc+1 (16-bit, 16'hFFFF wraps to 16'h0000), go ISSUE.
REQ-024 Fetch-to-valid latency SHALL be 2 cycles on hit (ISSUE->WAIT->HOLD); back-to-back throughput 1 instruction per 3 cycles.
REQ-025 pc_load=1 in any state SHALL set pc<=pc_load_value, clear retry count, clear fault, go ISSUE; instr_valid deasserts next cycle.
REQ-026 pc_load with simultaneous HOLD handshake: transfer counts as completed; pc takes pc_load_value, not pc+1.
REQ-027 FAULT: instr_valid=0, fault=1, tlb_addr=pc; exits only on pc_load or reset.
REQ-028 tlb_addr SHALL equal pc in every state; instr_valid SHALL be 0 outside HOLD.
REQ-029 instr_ready while instr_valid=0 SHALL be ignored.

Reset
REQ-030 Resetn=0 SHALL immediately force state ISSUE, pc=RESET_PC, retry count=0.
REQ-031 Reset values: instr_valid=0, instr=0, imm=0, imm_valid=0, fault=0, tlb_addr=RESET_PC.
REQ-032 Reset mid-fetch or mid-HOLD SHALL discard the pending instruction without handshake.

Structure
REQ-033 Opcode constants (MVI=4'b0100, MV=4'b0011, MVNZ=4'b0010, etc.), field positions (op [3:0], rX [6:4], rY [9:7]) and FSM state encoding SHALL live in shared package proc_pkg.
REQ-034 PC register with load/increment SHALL be sub-module pc_counter; FSM and latches stay in instruction_fetch.

Verification
REQ-035 Reset, TLB hits at addr 1,2 holding 16'h0004/16'h0002 then 16'h0014/16'h0003, instr_ready=1 -> instr 16'h0004 imm_valid=1 imm=2 at cycle 2, then 16'h0014 imm=3 at cycle 5.
REQ-036 Hold instr_ready=0 for 5 cycles in HOLD -> instr_valid=1, instr/imm/pc unchanged; ready=1 -> pc increments once.
REQ-037 tlb_hit=0 for 3 consecutive WAITs -> fault=1 after 6th cycle; pc_load=1 value 16'd5 -> fault=0, fetch from 5.
REQ-038 Two misses then hit -> no fault, instruction delivered, retry count cleared (next 2 misses still no fault).
REQ-039 pc_load value 16'd3 coincident with HOLD handshake -> one transfer completed, next tlb_addr=3.
REQ-040 pc=16'hFFFF accepted -> pc=16'h0000; Resetn low during WAIT -> instr_valid=0, pc=1 asynchronously.
